query_weight_stream_sink: RTL and testbench

Captures one parameter tensor delivered as a valid/ready stream of parallel beats and stores it in an internal RAM. Once the full tensor has arrived, the stored tensor is readable through a ROM-style port: `address0`/`ce0`/`q0`, two-cycle registered latency. The block is the receiving end of the weight-source streaming interface. It is used to load or readback-check layer parameters, for example `encoder_layer_1_attention_self_query_weight`, at runtime instead of from `.dat` initialisation.

---
 rtl/query_weight_stream_sink.sv | 168 ++++++++++++++++
 tb/tb_query_weight_stream_sink.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/query_weight_stream_sink.sv
// query_weight_stream_sink
//
// Receives one parameter tensor as a valid/ready stream of parallel beats,
// stores it in an internal RAM, and flags when the full tensor is present.
// The stored tensor can be read through a ROM-style port with two-cycle
// registered latency (address0 -> stage t0 -> q0, both gated by ce0).
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   data_in        N beat elements, element j packed at word bits [P*j +: P]
//   data_in_valid  beat valid
//   data_in_ready  beat ready (registered, high only in FILL)
//   release_buf    in FULL: discard the stored tensor and re-arm for a new fill
//   full           a complete tensor is stored (registered)
//   done           one-cycle pulse in the cycle after the last beat is written
//   address0       read word address (addresses >= IN_DEPTH read as zero)
//   ce0            read pipeline enable; 0 holds both read stages
//   q0             read data word
module query_weight_stream_sink #(
  parameter int TENSOR_SIZE_DIM_0 = 32,
  parameter int TENSOR_SIZE_DIM_1 = 1,
  parameter int PRECISION_0       = 16,
  parameter int PRECISION_1       = 3,
  parameter int PARALLELISM_DIM_0 = 1,
  parameter int PARALLELISM_DIM_1 = 1,
  parameter int IN_DEPTH          = TENSOR_SIZE_DIM_0 * TENSOR_SIZE_DIM_1 /
                                    (PARALLELISM_DIM_0 * PARALLELISM_DIM_1),
  parameter int ADDR_WIDTH        = $clog2(IN_DEPTH) + 1
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic [PRECISION_0-1:0]                                     data_in [PARALLELISM_DIM_0*PARALLELISM_DIM_1],
  input  logic                                                       data_in_valid,
  output logic                                                       data_in_ready,
  input  logic                                                       release_buf,
  output logic                                                       full,
  output logic                                                       done,
  input  logic [ADDR_WIDTH-1:0]                                      address0,
  input  logic                                                       ce0,
  output logic [PRECISION_0*PARALLELISM_DIM_0*PARALLELISM_DIM_1-1:0] q0
);

  localparam int N      = PARALLELISM_DIM_0 * PARALLELISM_DIM_1;
  localparam int WORD_W = PRECISION_0 * N;
  localparam int CNT_W  = $clog2(IN_DEPTH) + 1;
  localparam int IDX_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  // Fractional bits are metadata carried alongside the tensor; storage is
  // bit-exact. Reject a nonsensical configuration at elaboration.
  if (PRECISION_1 > PRECISION_0) begin : g_bad_frac
    $error("PRECISION_1 exceeds PRECISION_0");
  end

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   counter_q;
  logic               ready_q;
  logic               full_q;
  logic               done_q;

  logic [WORD_W-1:0]  ram [IN_DEPTH];
  logic [WORD_W-1:0]  wr_word;
  logic [WORD_W-1:0]  rd_word;
  logic [WORD_W-1:0]  t0_q;
  logic [WORD_W-1:0]  q0_q;

  logic               wr_en;
  logic               last_beat;

  // ready_q is only ever high in FILL, so a transfer can only happen there.
  assign wr_en     = data_in_valid && ready_q;
  assign last_beat = (counter_q == CNT_W'(IN_DEPTH - 1));

  always_comb begin
    wr_word = '0;
    for (int j = 0; j < N; j++) begin
      wr_word[PRECISION_0*j +: PRECISION_0] = data_in[j];
    end
  end

  // Control FSM with registered handshake/status outputs.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      counter_q <= '0;
      ready_q   <= 1'b0;
      full_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          state_q <= S_FILL;
          ready_q <= 1'b1;
        end
        S_FILL: begin
          if (wr_en) begin
            if (last_beat) begin
              // Drop ready on the accepting edge so nothing is taken in FULL.
              counter_q <= '0;
              state_q   <= S_FULL;
              ready_q   <= 1'b0;
              full_q    <= 1'b1;
              done_q    <= 1'b1;
            end else begin
              counter_q <= counter_q + CNT_W'(1);
            end
          end
        end
        S_FULL: begin
          if (release_buf) begin
            state_q   <= S_FILL;
            counter_q <= '0;
            ready_q   <= 1'b1;
            full_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= S_INIT;
          ready_q <= 1'b0;
          full_q  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the tensor RAM has no reset; a reset abandons a partial fill but
  // keeps the contents, and leaving it unreset lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[counter_q[IDX_W-1:0]] <= wr_word;
    end
  end

  // Out-of-range addresses read as zero instead of aliasing into the RAM.
  always_comb begin
    rd_word = '0;
    if (address0 < ADDR_WIDTH'(IN_DEPTH)) begin
      rd_word = ram[address0[IDX_W-1:0]];
    end
  end

  // Two-stage read pipeline; sampling ram on the write edge yields the
  // pre-write content (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0_q <= '0;
      q0_q <= '0;
    end else if (ce0) begin
      t0_q <= rd_word;
      q0_q <= t0_q;
    end
  end

  assign data_in_ready = ready_q;
  assign full          = full_q;
  assign done          = done_q;
  assign q0            = q0_q;

endmodule

// File: tb/tb_query_weight_stream_sink.sv
module tb_query_weight_stream_sink;

  localparam int DEPTH  = 32;
  localparam int DEPTH4 = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Main instance: N=1, 16-bit elements, 32 words.
  logic [15:0] din [1];
  logic        valid = 1'b0;
  logic        ready;
  logic        release_buf = 1'b0;
  logic        full;
  logic        done;
  logic [5:0]  addr = '0;
  logic        ce0 = 1'b0;
  logic [15:0] q0;

  // Wide instance: N=4, 8 words of 64 bits.
  logic [15:0] din4 [4];
  logic        valid4 = 1'b0;
  logic        ready4;
  logic        rel4 = 1'b0;
  logic        full4;
  logic        done4;
  logic [3:0]  addr4 = '0;
  logic        ce4 = 1'b0;
  logic [63:0] q4;

  int errors = 0;
  int checks = 0;

  logic [15:0] model  [DEPTH];
  logic [63:0] model4 [DEPTH4];
  logic [15:0] exp_q  [$];

  query_weight_stream_sink u_dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (din),
    .data_in_valid (valid),
    .data_in_ready (ready),
    .release_buf   (release_buf),
    .full          (full),
    .done          (done),
    .address0      (addr),
    .ce0           (ce0),
    .q0            (q0)
  );

  query_weight_stream_sink #(.PARALLELISM_DIM_0(4)) u_dut4 (
    .clk           (clk),
    .rst           (rst),
    .data_in       (din4),
    .data_in_valid (valid4),
    .data_in_ready (ready4),
    .release_buf   (rel4),
    .full          (full4),
    .done          (done4),
    .address0      (addr4),
    .ce0           (ce4),
    .q0            (q4)
  );

  always #5 clk = ~clk;

  // Streams nbeats beats of value base+index; optional random idle gaps.
  task automatic fill(input int base, input int nbeats, input bit gaps);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      valid  = 1'b1;
      din[0] = 16'(base + b);
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready beat %0d: got %b expected 1", b, ready);
      end
      @(posedge clk); #1;
      model[b] = 16'(base + b);
      checks++;
      if (b == DEPTH - 1) begin
        if ({done, full, ready} !== 3'b110) begin
          errors++;
          $display("FAIL fill_last {done,full,ready}: got %b expected 110", {done, full, ready});
        end
      end else if ({done, full} !== 2'b00) begin
        errors++;
        $display("FAIL fill_early beat %0d {done,full}: got %b expected 00", b, {done, full});
      end
    end
    valid = 1'b0;
  endtask

  // Reads lo..hi back-to-back; each expected word is queued at address
  // issue time and compared when it emerges two enabled edges later.
  task automatic read_range(input int lo, input int hi);
    logic [15:0] exp;
    for (int a = lo; a <= hi + 1; a++) begin
      ce0 = 1'b1;
      if (a <= hi) begin
        addr = 6'(a);
        exp_q.push_back((a < DEPTH) ? model[a] : 16'h0000);
      end else begin
        addr = '0;
      end
      @(posedge clk); #1;
      if (a > lo) begin
        exp = exp_q.pop_front();
        checks++;
        if (q0 !== exp) begin
          errors++;
          $display("FAIL read addr %0d: got %h expected %h", a - 1, q0, exp);
        end
      end
    end
    ce0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, full, done} !== 3'b000 || q0 !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: got rdy/full/done=%b q0=%h expected 000 0000", {ready, full, done}, q0);
    end
    checks++;
    if ({ready4, full4, done4} !== 3'b000 || q4 !== 64'h0) begin
      errors++;
      $display("FAIL reset_values4: got %b q4=%h expected 000 0", {ready4, full4, done4}, q4);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_init_edge: got %b expected 0", ready);
    end
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1 || ready4 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_init: got %b/%b expected 1/1", ready, ready4);
    end
  endtask

  task automatic test_wide();
    logic [63:0] exp;
    for (int b = 0; b < DEPTH4; b++) begin
      valid4 = 1'b1;
      if (b == 2) begin
        din4[0] = 16'hAAAA; din4[1] = 16'hBBBB; din4[2] = 16'hCCCC; din4[3] = 16'hDDDD;
        model4[b] = 64'hDDDDCCCCBBBBAAAA;
      end else begin
        for (int j = 0; j < 4; j++) din4[j] = 16'(16 * b + j + 1);
        model4[b] = {16'(16 * b + 4), 16'(16 * b + 3), 16'(16 * b + 2), 16'(16 * b + 1)};
      end
      @(posedge clk); #1;
    end
    valid4 = 1'b0;
    checks++;
    if ({done4, full4, ready4} !== 3'b110) begin
      errors++;
      $display("FAIL wide_done {done,full,ready}: got %b expected 110", {done4, full4, ready4});
    end
    ce4 = 1'b1; addr4 = 4'd2;
    @(posedge clk); #1;
    addr4 = 4'd5;
    @(posedge clk); #1;
    exp = model4[2];
    checks++;
    if (q4 !== exp) begin
      errors++;
      $display("FAIL wide_read addr 2: got %h expected %h", q4, exp);
    end
    @(posedge clk); #1;
    exp = model4[5];
    checks++;
    if (q4 !== exp) begin
      errors++;
      $display("FAIL wide_read addr 5: got %h expected %h", q4, exp);
    end
    ce4 = 1'b0;
  endtask

  task automatic test_stream();
    fill(16'h100, DEPTH, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({done, full, ready} !== 3'b010) begin
      errors++;
      $display("FAIL done_single_pulse {done,full,ready}: got %b expected 010", {done, full, ready});
    end
    read_range(0, DEPTH - 1);
  endtask

  task automatic test_full_hold_release();
    valid  = 1'b1;
    din[0] = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({ready, full} !== 2'b01) begin
        errors++;
        $display("FAIL full_hold cycle %0d {ready,full}: got %b expected 01", i, {ready, full});
      end
      @(posedge clk); #1;
    end
    valid = 1'b0;
    read_range(0, DEPTH - 1);
    release_buf = 1'b1;
    @(posedge clk); #1;
    release_buf = 1'b0;
    checks++;
    if ({ready, full} !== 2'b10) begin
      errors++;
      $display("FAIL release {ready,full}: got %b expected 10", {ready, full});
    end
    fill(16'h200, DEPTH, 1'b1);
    read_range(0, DEPTH - 1);
  endtask

  task automatic test_reset_midfill();
    release_buf = 1'b1;
    @(posedge clk); #1;
    release_buf = 1'b0;
    fill(16'h300, 12, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ready, full, done} !== 3'b000 || q0 !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got rdy/full/done=%b q0=%h expected 000 0000", {ready, full, done}, q0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", ready);
    end
    fill(16'h400, DEPTH, 1'b0);
    read_range(0, DEPTH - 1);
  endtask

  task automatic test_oor_and_hold();
    read_range(40, 40);
    ce0 = 1'b1; addr = 6'd5;
    @(posedge clk); #1;
    addr = 6'd6;
    @(posedge clk); #1;
    ce0 = 1'b0; addr = 6'd9;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q0 !== model[5]) begin
        errors++;
        $display("FAIL ce0_hold cycle %0d: got %h expected %h", i, q0, model[5]);
      end
    end
    ce0 = 1'b1;
    @(posedge clk); #1;
    ce0 = 1'b0;
    checks++;
    if (q0 !== model[6]) begin
      errors++;
      $display("FAIL ce0_hold_t0: got %h expected %h", q0, model[6]);
    end
  endtask

  initial begin
    din[0] = '0;
    for (int j = 0; j < 4; j++) din4[j] = '0;
    test_reset();
    test_wide();
    test_stream();
    test_full_hold_release();
    test_reset_midfill();
    test_oor_and_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
